// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer.
// Access-size decode and alignment rules live here.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MERGE,
    S_WR,
    S_FIN
  } state_t;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  function automatic logic [3:0] size_bytes(
    input logic [2:0] f3
  );
    case (f3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [2:0] off
  );
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off[1:0] != 2'b00;
      2'b11:   return off != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic illegal(
    input logic [2:0] f3,
    input logic       st
  );
    return (f3 == F3_BAD) || (st && f3[2]);
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Control-unit request side and data-memory side
// of the load/store sequencer.
interface lsu_mem_ctrl_if;

  logic        START;
  logic        IS_STORE;
  logic [2:0]  FUNCT3;
  logic [63:0] ADDR;
  logic [63:0] STORE_DATA;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [63:0] MDR;
  logic [63:0] MEM_ADDR;
  logic        MEM_WR;
  logic [63:0] MEM_WDATA;
  logic [63:0] MEM_RDATA;

  modport master (
    output START, IS_STORE, FUNCT3,
    output ADDR, STORE_DATA, MEM_RDATA,
    input  BUSY, DONE, ERR, MDR,
    input  MEM_ADDR, MEM_WR, MEM_WDATA
  );

  modport slave (
    input  START, IS_STORE, FUNCT3,
    input  ADDR, STORE_DATA, MEM_RDATA,
    output BUSY, DONE, ERR, MDR,
    output MEM_ADDR, MEM_WR, MEM_WDATA
  );

endinterface

// File: rtl/lsu_align.sv
// Byte lane select/extend for loads and byte merge
// for sub-word stores, both keyed by funct3 and offset.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  off,
  input  logic [63:0] data,
  input  logic [63:0] wdata,
  output logic [63:0] load_val,
  output logic [63:0] merged
);

  logic [5:0]  sh;
  logic [63:0] shifted;
  logic [63:0] wsh;
  logic [7:0]  base;
  logic [7:0]  mask;

  assign sh      = {off, 3'b000};
  assign shifted = data >> sh;
  assign wsh     = wdata << sh;
  assign base    = 8'((9'h1 << size_bytes(funct3)) - 9'h1);
  assign mask    = base << off;

  // Shift the addressed lane down and extend to 64 bits.
  always_comb begin
    load_val = shifted;
    case (funct3)
      F3_B:  load_val = {{56{shifted[7]}}, shifted[7:0]};
      F3_H:  load_val = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:  load_val = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU: load_val = {56'h0, shifted[7:0]};
      F3_HU: load_val = {48'h0, shifted[15:0]};
      F3_WU: load_val = {32'h0, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  // Replace the covered byte lanes with shifted store data.
  always_comb begin
    merged = data;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) merged[i*8 +: 8] = wsh[i*8 +: 8];
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: RMW for sub-word stores,
// aligned/extended loads into the MDR.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input logic         CLK,
  input logic         RESET,
  lsu_mem_ctrl_if.slave bus
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t state, nxt;

  logic [63:0]   addr_q;
  logic [63:0]   sdata_q;
  logic [63:0]   wbuf;
  logic [63:0]   mdr_q;
  logic [2:0]    f3_q;
  logic          st_q;
  logic          err_q;
  logic [CW-1:0] cnt;

  logic          err_in;
  logic          is_sd;
  logic          rd_last;
  logic          busy;
  logic [63:0]   align_in;
  logic [63:0]   load_val;
  logic [63:0]   merged;

  assign err_in = illegal(bus.FUNCT3, bus.IS_STORE)
               || misaligned(bus.FUNCT3, bus.ADDR[2:0]);
  assign is_sd   = bus.IS_STORE && (bus.FUNCT3 == F3_D);
  assign rd_last = cnt == CW'(MEM_LAT - 1);
  assign busy    = state != S_IDLE;

  assign align_in = (state == S_RD) ? bus.MEM_RDATA : wbuf;

  lsu_align u_align (
    .funct3   (f3_q),
    .off      (addr_q[2:0]),
    .data     (align_in),
    .wdata    (sdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  assign bus.BUSY      = busy;
  assign bus.DONE      = state == S_FIN;
  assign bus.ERR       = (state == S_FIN) && err_q;
  assign bus.MEM_WR    = state == S_WR;
  assign bus.MEM_WDATA = wbuf;
  assign bus.MDR       = mdr_q;
  assign bus.MEM_ADDR  = busy ? {addr_q[63:3], 3'b000} : '0;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next-state decode.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (bus.START) begin
          if (err_in)     nxt = S_FIN;
          else if (is_sd) nxt = S_WR;
          else            nxt = S_RD;
        end
      end
      S_RD:    if (rd_last) nxt = st_q ? S_MERGE : S_FIN;
      S_MERGE: nxt = S_WR;
      S_WR:    nxt = S_FIN;
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Request latches, RD counter, write buffer and MDR.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_q  <= '0;
      sdata_q <= '0;
      f3_q    <= '0;
      st_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
      wbuf    <= '0;
      mdr_q   <= '0;
    end else begin
      if (state == S_IDLE && bus.START) begin
        addr_q  <= bus.ADDR;
        sdata_q <= bus.STORE_DATA;
        f3_q    <= bus.FUNCT3;
        st_q    <= bus.IS_STORE;
        err_q   <= err_in;
        cnt     <= '0;
        if (is_sd && !err_in) wbuf <= bus.STORE_DATA;
      end
      if (state == S_RD) begin
        cnt <= cnt + CW'(1);
        if (rd_last) begin
          if (st_q) wbuf  <= bus.MEM_RDATA;
          else      mdr_q <= load_val;
        end
      end
      if (state == S_MERGE) wbuf <= merged;
    end
  end

endmodule
